// File: rtl/pt_updown_counter_pkg.sv
// rtl/pt_updown_counter_pkg.sv - shared direction encoding and MAX default helper for the up/down counter
package pt_updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int max_default(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/pt_updown_counter_if.sv
// rtl/pt_updown_counter_if.sv - control/data bundle of the up/down counter macro
interface pt_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             CE;
    logic             CI;
    logic             LOAD;
    logic             UP;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             CO;

    modport master (output CE, CI, LOAD, UP, D, input Q, TC, CO);
    modport slave  (input CE, CI, LOAD, UP, D, output Q, TC, CO);
endinterface

// File: rtl/pt_toggle_slice.sv
// rtl/pt_toggle_slice.sv - one-bit toggle register with synchronous reset and load
module pt_toggle_slice (
    input  logic CLK,
    input  logic RST,
    input  logic LD,
    input  logic DV,
    input  logic T,
    input  logic EN,
    output logic Q
);

    always_ff @(posedge CLK) begin
        if (RST)
            Q <= 1'b0;
        else if (LD)
            Q <= DV;
        else if (T && EN)
            Q <= ~Q;
    end

endmodule

// File: rtl/pt_updown_counter.sv
// rtl/pt_updown_counter.sv - loadable cascadable up/down counter built from toggle slices
module pt_updown_counter
    import pt_updown_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MAX   = max_default(WIDTH)
) (
    input  logic                CLK,
    input  logic                RST,
    pt_updown_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_Q = MAX[WIDTH-1:0];

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] dv;
    logic             up;
    logic             count;
    logic             run;
    logic             wrap_ld;
    logic             ld;

    always_comb begin
        up    = (bus.UP == DIR_UP);
        count = bus.CE & bus.CI;
        // Each bit toggles when every lower bit sits at its wrap-boundary value
        run   = 1'b1;
        t     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = run;
            run  = run & (up ? q[i] : ~q[i]);
        end
        // Modulus wrap (and recovery from an out-of-range load) reuses the load mux
        wrap_ld = count & (up ? (q >= MAX_Q) : (q == '0));
        ld      = bus.LOAD | wrap_ld;
        dv      = bus.LOAD ? bus.D : (up ? '0 : MAX_Q);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        pt_toggle_slice u_slice (
            .CLK (CLK),
            .RST (RST),
            .LD  (ld),
            .DV  (dv[i]),
            .T   (t[i]),
            .EN  (count),
            .Q   (q[i])
        );
    end

    assign bus.Q  = q;
    assign bus.TC = up ? (q == MAX_Q) : (q == '0);
    assign bus.CO = bus.TC & count;

endmodule

// File: tb/tb_pt_updown_counter.sv
// tb/tb_pt_updown_counter.sv - directed self-checking bench for pt_updown_counter
module tb_pt_updown_counter;
    import pt_updown_counter_pkg::*;

    logic       CLK = 1'b0;
    logic       rst;
    logic       ce, ci, load, up;
    logic [3:0] d;
    logic [7:0] dc;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 CLK = ~CLK;

    pt_updown_counter_if #(.WIDTH(4)) if_a  ();
    pt_updown_counter_if #(.WIDTH(4)) if_b  ();
    pt_updown_counter_if #(.WIDTH(4)) if_lo ();
    pt_updown_counter_if #(.WIDTH(4)) if_hi ();

    assign if_a.CE  = ce;  assign if_a.CI  = ci;  assign if_a.LOAD  = load; assign if_a.UP  = up; assign if_a.D  = d;
    assign if_b.CE  = ce;  assign if_b.CI  = ci;  assign if_b.LOAD  = load; assign if_b.UP  = up; assign if_b.D  = d;
    assign if_lo.CE = ce;  assign if_lo.CI = ci;  assign if_lo.LOAD = load; assign if_lo.UP = up; assign if_lo.D = dc[3:0];
    assign if_hi.CE = ce;  assign if_hi.CI = if_lo.CO; assign if_hi.LOAD = load; assign if_hi.UP = up; assign if_hi.D = dc[7:4];

    pt_updown_counter #(.WIDTH(4), .MAX(15)) dut_a  (.CLK(CLK), .RST(rst), .bus(if_a));
    pt_updown_counter #(.WIDTH(4), .MAX(9))  dut_b  (.CLK(CLK), .RST(rst), .bus(if_b));
    pt_updown_counter #(.WIDTH(4), .MAX(15)) dut_lo (.CLK(CLK), .RST(rst), .bus(if_lo));
    pt_updown_counter #(.WIDTH(4), .MAX(15)) dut_hi (.CLK(CLK), .RST(rst), .bus(if_hi));

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; ci = 1'b0; load = 1'b0; up = DIR_UP; d = '0; dc = '0;
        step(); step();
        check("rst_q", int'(if_a.Q), 0);
        check("rst_tc_up", int'(if_a.TC), 0);
        check("rst_co", int'(if_a.CO), 0);
        up = DIR_DOWN; #1;
        check("rst_tc_down", int'(if_a.TC), 1);

        // Full-range up count with wrap
        up = DIR_UP; rst = 1'b0; ce = 1'b1; ci = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            check($sformatf("up_q%0d", i), int'(if_a.Q), i);
        end
        check("up_tc15", int'(if_a.TC), 1);
        check("up_co15", int'(if_a.CO), 1);
        step();
        check("up_wrap", int'(if_a.Q), 0);
        check("up_tc_after_wrap", int'(if_a.TC), 0);

        // Short modulus down wrap
        rst = 1'b1; step(); rst = 1'b0;
        up = DIR_DOWN; #1;
        check("b_tc_zero_down", int'(if_b.TC), 1);
        check("b_co_zero_down", int'(if_b.CO), 1);
        step();
        check("b_down_wrap", int'(if_b.Q), 9);
        check("a_down_wrap", int'(if_a.Q), 15);
        step();
        check("b_down_8", int'(if_b.Q), 8);
        step();
        check("b_down_7", int'(if_b.Q), 7);
        load = 1'b1; d = 4'd9; step(); load = 1'b0; up = DIR_UP; #1;
        check("b_tc_at_max", int'(if_b.TC), 1);
        step();
        check("b_up_wrap", int'(if_b.Q), 0);

        // Load above MAX
        load = 1'b1; d = 4'd12; step(); load = 1'b0;
        check("b_load_over", int'(if_b.Q), 12);
        step();
        check("b_up_from_over", int'(if_b.Q), 0);
        load = 1'b1; step(); load = 1'b0; up = DIR_DOWN;
        step();
        check("b_down_from_over", int'(if_b.Q), 11);

        // Load and priority
        ce = 1'b0; up = DIR_UP; load = 1'b1; d = 4'hA; step();
        check("load_no_ce", int'(if_a.Q), 10);
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_over_load", int'(if_a.Q), 0);
        ce = 1'b1; ci = 1'b1; step();
        check("load_over_count", int'(if_a.Q), 10);

        // Enable gating
        d = 4'd3; step(); load = 1'b0; ci = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("gate_q%0d", i), int'(if_a.Q), 3);
            check($sformatf("gate_co%0d", i), int'(if_a.CO), 0);
        end
        load = 1'b1; d = 4'd0; up = DIR_DOWN; step(); load = 1'b0;
        check("gate_tc_zero", int'(if_a.TC), 1);
        check("gate_co_zero", int'(if_a.CO), 0);

        // Direction flip
        ci = 1'b1; load = 1'b1; d = 4'd5; step(); load = 1'b0;
        up = DIR_UP;   step(); check("flip_6", int'(if_a.Q), 6);
        up = DIR_DOWN; step(); check("flip_5", int'(if_a.Q), 5);
        up = DIR_UP;   step(); check("flip_6b", int'(if_a.Q), 6);

        // Cascade
        load = 1'b1; dc = 8'h0E; step(); load = 1'b0;
        check("casc_0e", int'({if_hi.Q, if_lo.Q}), 8'h0E);
        step();
        check("casc_0f", int'({if_hi.Q, if_lo.Q}), 8'h0F);
        check("casc_lo_co", int'(if_lo.CO), 1);
        step();
        check("casc_10", int'({if_hi.Q, if_lo.Q}), 8'h10);
        load = 1'b1; dc = 8'hFF; step(); load = 1'b0;
        check("casc_tc_lo", int'(if_lo.TC), 1);
        check("casc_tc_hi", int'(if_hi.TC), 1);
        check("casc_co_hi", int'(if_hi.CO), 1);
        step();
        check("casc_00", int'({if_hi.Q, if_lo.Q}), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
